// File: rtl/video_fx_pkg.sv
// Shared types for the video effect router: bus struct, FSM states and source-code helpers.
package video_fx_pkg;

  localparam int unsigned SRC_BASE = 0;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        ad;
    logic [23:0] pix;
  } vid_bus_t;

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT} route_state_t;

  // Codes above the slot count alias to the base bus.
  function automatic logic src_is_base(input int unsigned code, input int unsigned num_slots);
    return (code == SRC_BASE) || (code > num_slots);
  endfunction

endpackage

// File: rtl/vfx_route_checker.sv
// Frame-boundary config capture, routing-loop walk and committed source table.
// Loop walk is built only when VIDEO_FX_ROUTER_LOOP_CHECK_EN is defined.
module vfx_route_checker
  import video_fx_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SRC_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                       clk_pixel,
  input  logic                       rst,
  input  logic                       i_new_frame,
  input  logic [NUM_SLOTS*SRC_W-1:0] i_cfg_src,
  input  logic [SRC_W-1:0]           i_cfg_out_src,
  output logic [NUM_SLOTS*SRC_W-1:0] o_active_src,
  output logic [SRC_W-1:0]           o_active_out_src,
  output logic                       o_cfg_busy,
  output logic [NUM_SLOTS-1:0]       o_loop_flags
);

  route_state_t               r_state, w_state_nxt;
  logic [NUM_SLOTS*SRC_W-1:0] r_pend, r_active;
  logic [SRC_W-1:0]           r_pend_out, r_active_out;
  logic [NUM_SLOTS-1:0]       r_loop_flags, w_looped;
  logic                       w_capture, w_walk_done;

`ifdef VIDEO_FX_ROUTER_LOOP_CHECK_EN
  localparam int unsigned IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [IDX_W-1:0]     r_idx, w_idx_nxt;
  logic [SRC_W-1:0]     r_cur, w_cur_nxt;
  logic [SRC_W-1:0]     r_step, w_step_nxt;
  logic [NUM_SLOTS-1:0] r_looped, w_looped_nxt;

  // Follow slot idx upstream one hop per cycle; NUM_SLOTS hops without reaching base is a loop.
  always_comb begin
    w_idx_nxt    = r_idx;
    w_cur_nxt    = r_cur;
    w_step_nxt   = r_step;
    w_looped_nxt = r_looped;
    w_walk_done  = 1'b0;
    if (w_capture) begin
      w_idx_nxt    = '0;
      w_cur_nxt    = i_cfg_src[0 +: SRC_W];
      w_step_nxt   = '0;
      w_looped_nxt = '0;
    end else if (r_state == CHECK) begin
      if (src_is_base(32'(r_cur), NUM_SLOTS) || (32'(r_step) == NUM_SLOTS)) begin
        if (!src_is_base(32'(r_cur), NUM_SLOTS)) w_looped_nxt[r_idx] = 1'b1;
        if (32'(r_idx) == NUM_SLOTS - 1) begin
          w_walk_done = 1'b1;
        end else begin
          w_idx_nxt  = r_idx + IDX_W'(1);
          w_cur_nxt  = r_pend[(32'(r_idx) + 1) * SRC_W +: SRC_W];
          w_step_nxt = '0;
        end
      end else begin
        w_cur_nxt  = r_pend[(32'(r_cur) - 1) * SRC_W +: SRC_W];
        w_step_nxt = r_step + SRC_W'(1);
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      r_idx    <= '0;
      r_cur    <= '0;
      r_step   <= '0;
      r_looped <= '0;
    end else begin
      r_idx    <= w_idx_nxt;
      r_cur    <= w_cur_nxt;
      r_step   <= w_step_nxt;
      r_looped <= w_looped_nxt;
    end
  end

  assign w_looped = r_looped;
`else
  assign w_walk_done = 1'b0;
  assign w_looped    = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_new_frame) begin
          w_capture = 1'b1;
`ifdef VIDEO_FX_ROUTER_LOOP_CHECK_EN
          w_state_nxt = CHECK;
`else
          w_state_nxt = COMMIT;
`endif
        end
      end
      CHECK:   if (w_walk_done) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pend       <= '0;
      r_pend_out   <= '0;
      r_active     <= '0;
      r_active_out <= '0;
      r_loop_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_pend     <= i_cfg_src;
        r_pend_out <= i_cfg_out_src;
      end
      if (r_state == COMMIT) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          r_active[i*SRC_W +: SRC_W] <= w_looped[i] ? SRC_W'(SRC_BASE) : r_pend[i*SRC_W +: SRC_W];
        end
        r_active_out <= r_pend_out;
        r_loop_flags <= w_looped;
      end
    end
  end

  assign o_active_src     = r_active;
  assign o_active_out_src = r_active_out;
  assign o_cfg_busy       = (r_state != IDLE);
  assign o_loop_flags     = r_loop_flags;

endmodule

// File: rtl/video_fx_router.sv
// Runtime-reorderable effect chain: registered per-slot feed and output muxes over the video bus.
// Loop checking of new routes is enabled by VIDEO_FX_ROUTER_LOOP_CHECK_EN.
module video_fx_router
  import video_fx_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SRC_W     = $clog2(NUM_SLOTS + 1),
  parameter int unsigned PIX_W     = 24
) (
  input  logic                       clk_pixel,
  input  logic                       rst,
  input  logic                       i_new_frame,
  input  logic [NUM_SLOTS*SRC_W-1:0] i_cfg_src,
  input  logic [SRC_W-1:0]           i_cfg_out_src,
  input  logic [10:0]                i_base_h,
  input  logic [9:0]                 i_base_v,
  input  logic                       i_base_ad,
  input  logic [PIX_W-1:0]           i_base_pix,
  input  logic [NUM_SLOTS*11-1:0]    i_from_h,
  input  logic [NUM_SLOTS*10-1:0]    i_from_v,
  input  logic [NUM_SLOTS-1:0]       i_from_ad,
  input  logic [NUM_SLOTS*PIX_W-1:0] i_from_pix,
  output logic [NUM_SLOTS*11-1:0]    o_to_h,
  output logic [NUM_SLOTS*10-1:0]    o_to_v,
  output logic [NUM_SLOTS-1:0]       o_to_ad,
  output logic [NUM_SLOTS*PIX_W-1:0] o_to_pix,
  output logic [10:0]                o_out_h,
  output logic [9:0]                 o_out_v,
  output logic                       o_out_ad,
  output logic [PIX_W-1:0]           o_out_pix,
  output logic                       o_cfg_busy,
  output logic [NUM_SLOTS-1:0]       o_loop_flags
);

  logic [NUM_SLOTS*SRC_W-1:0] w_active_src;
  logic [SRC_W-1:0]           w_active_out_src;
  vid_bus_t                   w_src    [NUM_SLOTS+1];
  vid_bus_t                   w_to_nxt [NUM_SLOTS];
  vid_bus_t                   w_out_nxt;
  vid_bus_t                   r_to     [NUM_SLOTS];
  vid_bus_t                   r_out;

  vfx_route_checker #(
    .NUM_SLOTS (NUM_SLOTS),
    .SRC_W     (SRC_W)
  ) u_checker (
    .clk_pixel        (clk_pixel),
    .rst              (rst),
    .i_new_frame      (i_new_frame),
    .i_cfg_src        (i_cfg_src),
    .i_cfg_out_src    (i_cfg_out_src),
    .o_active_src     (w_active_src),
    .o_active_out_src (w_active_out_src),
    .o_cfg_busy       (o_cfg_busy),
    .o_loop_flags     (o_loop_flags)
  );

  // Source index 0 is the base bus, index k is the return of slot k-1.
  always_comb begin
    w_src[0].h   = i_base_h;
    w_src[0].v   = i_base_v;
    w_src[0].ad  = i_base_ad;
    w_src[0].pix = i_base_pix;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      w_src[k+1].h   = i_from_h[k*11 +: 11];
      w_src[k+1].v   = i_from_v[k*10 +: 10];
      w_src[k+1].ad  = i_from_ad[k];
      w_src[k+1].pix = i_from_pix[k*PIX_W +: PIX_W];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_to_nxt[i] = w_src[0];
      if (!src_is_base(32'(w_active_src[i*SRC_W +: SRC_W]), NUM_SLOTS)) begin
        w_to_nxt[i] = w_src[w_active_src[i*SRC_W +: SRC_W]];
      end
    end
    w_out_nxt = w_src[0];
    if (!src_is_base(32'(w_active_out_src), NUM_SLOTS)) w_out_nxt = w_src[w_active_out_src];
  end

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_to[i] <= '0;
      r_out <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) r_to[i] <= w_to_nxt[i];
      r_out <= w_out_nxt;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_to
    assign o_to_h[g*11 +: 11]       = r_to[g].h;
    assign o_to_v[g*10 +: 10]       = r_to[g].v;
    assign o_to_ad[g]               = r_to[g].ad;
    assign o_to_pix[g*PIX_W +: PIX_W] = r_to[g].pix;
  end

  assign o_out_h   = r_out.h;
  assign o_out_v   = r_out.v;
  assign o_out_ad  = r_out.ad;
  assign o_out_pix = r_out.pix;

endmodule

// File: tb/tb_video_fx_router.sv
// Directed self-checking bench for video_fx_router (NUM_SLOTS=4); expectations follow
// VIDEO_FX_ROUTER_LOOP_CHECK_EN when it is defined.
module tb_video_fx_router;

  localparam int N  = 4;
  localparam int SW = 3;
  localparam int PW = 24;
`ifdef VIDEO_FX_ROUTER_LOOP_CHECK_EN
  localparam bit LoopChk = 1'b1;
`else
  localparam bit LoopChk = 1'b0;
`endif

  logic            clk_pixel = 1'b0;
  logic            rst = 1'b1;
  logic            new_frame = 1'b0;
  logic [N*SW-1:0] cfg_src = '0;
  logic [SW-1:0]   cfg_out_src = '0;
  logic [10:0]     base_h;
  logic [9:0]      base_v;
  logic            base_ad;
  logic [PW-1:0]   base_pix;
  logic [N*11-1:0] from_h, to_h;
  logic [N*10-1:0] from_v, to_v;
  logic [N-1:0]    from_ad, to_ad;
  logic [N*PW-1:0] from_pix, to_pix;
  logic [10:0]     out_h;
  logic [9:0]      out_v;
  logic            out_ad;
  logic [PW-1:0]   out_pix;
  logic            cfg_busy;
  logic [N-1:0]    loop_flags;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  video_fx_router #(.NUM_SLOTS(N), .SRC_W(SW), .PIX_W(PW)) dut (
    .clk_pixel     (clk_pixel),
    .rst           (rst),
    .i_new_frame   (new_frame),
    .i_cfg_src     (cfg_src),
    .i_cfg_out_src (cfg_out_src),
    .i_base_h      (base_h),
    .i_base_v      (base_v),
    .i_base_ad     (base_ad),
    .i_base_pix    (base_pix),
    .i_from_h      (from_h),
    .i_from_v      (from_v),
    .i_from_ad     (from_ad),
    .i_from_pix    (from_pix),
    .o_to_h        (to_h),
    .o_to_v        (to_v),
    .o_to_ad       (to_ad),
    .o_to_pix      (to_pix),
    .o_out_h       (out_h),
    .o_out_v       (out_v),
    .o_out_ad      (out_ad),
    .o_out_pix     (out_pix),
    .o_cfg_busy    (cfg_busy),
    .o_loop_flags  (loop_flags)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  // Distinct {h,v,ad,pix} per seed and source code (0 = base, k = slot k-1 return).
  function automatic logic [45:0] bus_val(input int seed, input int s);
    logic [10:0] h;
    logic [9:0]  v;
    logic        ad;
    logic [23:0] pix;
    h   = 11'(seed * 3 + s * 100);
    v   = 10'(seed * 5 + s * 50);
    ad  = 1'((seed + s) % 2);
    pix = {8'(s), 8'(seed), 8'(seed ^ 'h5A)};
    return {h, v, ad, pix};
  endfunction

  task automatic drive_all(input int seed);
    logic [45:0] b;
    b = bus_val(seed, 0);
    {base_h, base_v, base_ad, base_pix} = b;
    for (int k = 0; k < N; k++) begin
      b = bus_val(seed, k + 1);
      from_h[k*11 +: 11] = b[45:35];
      from_v[k*10 +: 10] = b[34:25];
      from_ad[k]         = b[24];
      from_pix[k*PW +: PW] = b[23:0];
    end
  endtask

  function automatic logic [45:0] to_bus(input int k);
    return {to_h[k*11 +: 11], to_v[k*10 +: 10], to_ad[k], to_pix[k*PW +: PW]};
  endfunction

  function automatic logic [45:0] out_bus();
    return {out_h, out_v, out_ad, out_pix};
  endfunction

  task automatic set_cfg(input int s0, input int s1, input int s2, input int s3, input int so);
    cfg_src     = {3'(s3), 3'(s2), 3'(s1), 3'(s0)};
    cfg_out_src = 3'(so);
  endtask

  // Pulse new_frame, then count busy cycles (bounded); optionally re-pulse with junk config.
  task automatic pulse_and_wait(input bit second, output int n);
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    n = 0;
    while (cfg_busy && n < 40) begin
      if (second && n == 0) begin
        new_frame   = 1'b1;
        cfg_src     = '0;
        cfg_out_src = '0;
      end else begin
        new_frame = 1'b0;
      end
      n++;
      step();
    end
    new_frame = 1'b0;
  endtask

  initial begin
    drive_all(1);
    repeat (3) step();
    check("rst_out", 64'(out_bus()), 64'(0));
    check("rst_to3", 64'(to_bus(3)), 64'(0));
    check("rst_busy", 64'(cfg_busy), 64'(0));
    check("rst_flags", 64'(loop_flags), 64'(0));

    rst = 1'b0;
    drive_all(2);
    base_pix = 24'h112233;
    base_ad  = 1'b1;
    step();
    check("base_pix", 64'(out_pix), 64'h112233);
    check("base_ad", 64'(out_ad), 64'(1));
    for (int k = 0; k < N; k++) check("base_to_pix", 64'(to_pix[k*PW +: PW]), 64'h112233);
    check("base_flags", 64'(loop_flags), 64'(0));

    // slot1 <- slot0, output <- slot1
    set_cfg(0, 1, 0, 0, 2);
    pulse_and_wait(1'b0, cyc);
    check("chain_busy_cyc", 64'(cyc), LoopChk ? 64'(6) : 64'(1));
    for (int seed = 10; seed < 12; seed++) begin
      drive_all(seed);
      step();
      check("chain_out", 64'(out_bus()), 64'(bus_val(seed, 2)));
      check("chain_to1", 64'(to_bus(1)), 64'(bus_val(seed, 1)));
      check("chain_to0", 64'(to_bus(0)), 64'(bus_val(seed, 0)));
    end

    // Mid-frame change without new_frame has no effect.
    cfg_out_src = 3'd3;
    repeat (2) step();
    drive_all(12);
    step();
    check("midframe_out", 64'(out_bus()), 64'(bus_val(12, 2)));

    // 2<->3 loop, with a second pulse carrying junk config during the check.
    set_cfg(0, 1, 4, 3, 3);
    pulse_and_wait(1'b1, cyc);
    check("loop_busy_cyc", 64'(cyc), LoopChk ? 64'(14) : 64'(1));
    check("loop_flags", 64'(loop_flags), LoopChk ? 64'b1100 : 64'(0));
    check("loop_busy_low", 64'(cfg_busy), 64'(0));
    drive_all(20);
    step();
    check("loop_to2", 64'(to_bus(2)), 64'(bus_val(20, LoopChk ? 0 : 4)));
    check("loop_to3", 64'(to_bus(3)), 64'(bus_val(20, LoopChk ? 0 : 3)));
    check("loop_to1", 64'(to_bus(1)), 64'(bus_val(20, 1)));
    check("loop_out", 64'(out_bus()), 64'(bus_val(20, 3)));

    // Invalid output code selects base.
    set_cfg(0, 0, 0, 0, 7);
    pulse_and_wait(1'b0, cyc);
    check("inv_busy_cyc", 64'(cyc), LoopChk ? 64'(5) : 64'(1));
    check("inv_flags", 64'(loop_flags), 64'(0));
    drive_all(30);
    step();
    check("inv_out", 64'(out_bus()), 64'(bus_val(30, 0)));

    // Reset during the walk restores all-base routing.
    set_cfg(2, 1, 4, 3, 2);
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_busy", 64'(cfg_busy), 64'(0));
    check("rstmid_flags", 64'(loop_flags), 64'(0));
    drive_all(40);
    step();
    check("rstmid_out", 64'(out_bus()), 64'(bus_val(40, 0)));
    check("rstmid_to0", 64'(to_bus(0)), 64'(bus_val(40, 0)));
    check("rstmid_busy2", 64'(cfg_busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
